// File: rtl/trap_ctrl.sv
// Trap controller: owns the CSR write port, sequences reset init, trap entry and mret, and drives stall/flush/redirect.
// Build option TRAP_CTRL_VECTORED_EN: vectored interrupt targets when mtvec mode is 01.
module trap_ctrl #(
  parameter int          CSR_ADDRESS_WIDTH = 12,
  parameter logic [31:0] MTVEC_RESET       = 32'h0000_0100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_csr_we,
  input  logic [CSR_ADDRESS_WIDTH-1:0] ex_csr_waddr,
  input  logic [31:0]                  ex_csr_wdata,
  input  logic                         exc_valid,
  input  logic [3:0]                   exc_cause,
  input  logic [31:0]                  exc_pc,
  input  logic [31:0]                  exc_tval,
  input  logic                         mret_valid,
  input  logic                         irq_ext,
  input  logic                         irq_soft,
  input  logic                         irq_timer,
  input  logic                         int_ok,
  input  logic [31:0]                  int_pc,
  output logic                         csr_we,
  output logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr,
  output logic [31:0]                  csr_wdata,
  output logic                         stall,
  output logic                         flush,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc
);

  localparam logic [3:0] S_HOLD    = 4'd0;
  localparam logic [3:0] S_INIT_ST = 4'd1;
  localparam logic [3:0] S_INIT_IE = 4'd2;
  localparam logic [3:0] S_INIT_TV = 4'd3;
  localparam logic [3:0] S_IDLE    = 4'd4;
  localparam logic [3:0] S_E_EPC   = 4'd5;
  localparam logic [3:0] S_E_CAUSE = 4'd6;
  localparam logic [3:0] S_E_TVAL  = 4'd7;
  localparam logic [3:0] S_E_ST    = 4'd8;
  localparam logic [3:0] S_M_ST    = 4'd9;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MSTATUS = CSR_ADDRESS_WIDTH'('h300);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MIE     = CSR_ADDRESS_WIDTH'('h304);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MTVEC   = CSR_ADDRESS_WIDTH'('h305);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MEPC    = CSR_ADDRESS_WIDTH'('h341);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MCAUSE  = CSR_ADDRESS_WIDTH'('h342);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] A_MTVAL   = CSR_ADDRESS_WIDTH'('h343);

  logic [3:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] sh_mstatus_q, sh_mie_q, sh_mtvec_q, sh_mepc_q;

  logic [31:0] irq_vec, irq_act;
  logic        int_pend;
  logic [3:0]  int_code;
  logic [31:0] st_trap, st_mret;
  logic [31:0] trap_target;

  assign irq_vec  = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign irq_act  = irq_vec & sh_mie_q;
  // A same-cycle EX CSR write wins; the interrupt is re-evaluated next cycle.
  assign int_pend = sh_mstatus_q[3] & int_ok & ~ex_csr_we & (|irq_act);

  always_comb begin
    int_code = 4'd7;
    if (irq_act[11])     int_code = 4'd11;
    else if (irq_act[3]) int_code = 4'd3;
  end

  // Trap entry: MPIE<-MIE, MIE<-0, MPP<-M. mret: MIE<-MPIE, MPIE<-1, MPP<-M.
  assign st_trap = {sh_mstatus_q[31:13], 2'b11, sh_mstatus_q[10:8], sh_mstatus_q[3],
                    sh_mstatus_q[6:4], 1'b0, sh_mstatus_q[2:0]};
  assign st_mret = {sh_mstatus_q[31:13], 2'b11, sh_mstatus_q[10:8], 1'b1,
                    sh_mstatus_q[6:4], sh_mstatus_q[7], sh_mstatus_q[2:0]};

`ifdef TRAP_CTRL_VECTORED_EN
  always_comb begin
    trap_target = {sh_mtvec_q[31:2], 2'b00};
    if (cause_q[31] && (sh_mtvec_q[1:0] == 2'b01))
      trap_target = {sh_mtvec_q[31:2], 2'b00} + {26'b0, cause_q[3:0], 2'b00};
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^sh_mtvec_q[1:0];
  assign trap_target       = {sh_mtvec_q[31:2], 2'b00};
`endif

  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = 32'h0;
    stall          = 1'b1;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      S_HOLD: begin
        state_d = S_INIT_ST;
      end
      S_INIT_ST: begin
        csr_we    = 1'b1;
        csr_waddr = A_MSTATUS;
        state_d   = S_INIT_IE;
      end
      S_INIT_IE: begin
        csr_we    = 1'b1;
        csr_waddr = A_MIE;
        state_d   = S_INIT_TV;
      end
      S_INIT_TV: begin
        csr_we    = 1'b1;
        csr_waddr = A_MTVEC;
        csr_wdata = MTVEC_RESET;
        state_d   = S_IDLE;
      end
      S_IDLE: begin
        stall = 1'b0;
        if (exc_valid) begin
          stall   = 1'b1;
          flush   = 1'b1;
          epc_d   = exc_pc;
          cause_d = {28'b0, exc_cause};
          tval_d  = exc_tval;
          state_d = S_E_EPC;
        end else if (int_pend) begin
          stall   = 1'b1;
          flush   = 1'b1;
          epc_d   = int_pc;
          cause_d = {1'b1, 27'b0, int_code};
          tval_d  = 32'h0;
          state_d = S_E_EPC;
        end else if (mret_valid) begin
          stall   = 1'b1;
          state_d = S_M_ST;
        end else begin
          csr_we    = ex_csr_we;
          csr_waddr = ex_csr_waddr;
          csr_wdata = ex_csr_wdata;
        end
      end
      S_E_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = epc_q;
        state_d   = S_E_CAUSE;
      end
      S_E_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = cause_q;
        state_d   = S_E_TVAL;
      end
      S_E_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = A_MTVAL;
        csr_wdata = tval_q;
        state_d   = S_E_ST;
      end
      S_E_ST: begin
        csr_we         = 1'b1;
        csr_waddr      = A_MSTATUS;
        csr_wdata      = st_trap;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        state_d        = S_IDLE;
      end
      S_M_ST: begin
        csr_we         = 1'b1;
        csr_waddr      = A_MSTATUS;
        csr_wdata      = st_mret;
        redirect_valid = 1'b1;
        redirect_pc    = sh_mepc_q;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HOLD;
      epc_q        <= 32'h0;
      cause_q      <= 32'h0;
      tval_q       <= 32'h0;
      sh_mstatus_q <= 32'h0;
      sh_mie_q     <= 32'h0;
      sh_mtvec_q   <= 32'h0;
      sh_mepc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      if (state_q == S_HOLD) begin
        sh_mstatus_q <= 32'h0;
        sh_mie_q     <= 32'h0;
        sh_mtvec_q   <= 32'h0;
        sh_mepc_q    <= 32'h0;
      end else if (csr_we) begin
        // Shadows track the write port so they never diverge from the CSR file.
        case (csr_waddr)
          A_MSTATUS: sh_mstatus_q <= csr_wdata;
          A_MIE:     sh_mie_q     <= csr_wdata;
          A_MTVEC:   sh_mtvec_q   <= csr_wdata;
          A_MEPC:    sh_mepc_q    <= csr_wdata;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: init, pass-through, exceptions, interrupts, mret, collisions, mid-sequence reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_csr_we;
  logic [11:0] ex_csr_waddr;
  logic [31:0] ex_csr_wdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_valid;
  logic        irq_ext, irq_soft, irq_timer;
  logic        int_ok;
  logic [31:0] int_pc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

`ifdef TRAP_CTRL_VECTORED_EN
  localparam logic [31:0] TGT_TIMER = 32'h0000_011C;
  localparam logic [31:0] TGT_EXT   = 32'h0000_012C;
`else
  localparam logic [31:0] TGT_TIMER = 32'h0000_0100;
  localparam logic [31:0] TGT_EXT   = 32'h0000_0100;
`endif

  always #5 clk = ~clk;

  trap_ctrl #(.CSR_ADDRESS_WIDTH(12), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid),
    .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
    .int_ok(int_ok), .int_pc(int_pc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check_val({tag, "_we"}, {31'b0, csr_we}, 32'd1);
    check_val({tag, "_addr"}, {20'b0, csr_waddr}, addr);
    check_val({tag, "_data"}, csr_wdata, data);
  endtask

  // Entered in the HOLD cycle right after rst has been released.
  task automatic init_seq(input string tag);
    check_val({tag, "_hold_stall"}, {31'b0, stall}, 32'd1);
    check_val({tag, "_hold_we"}, {31'b0, csr_we}, 32'd0);
    tick();
    expect_wr({tag, "_mstatus"}, 32'h300, 32'h0);
    check_val({tag, "_st_stall"}, {31'b0, stall}, 32'd1);
    tick();
    expect_wr({tag, "_mie"}, 32'h304, 32'h0);
    tick();
    expect_wr({tag, "_mtvec"}, 32'h305, 32'h100);
    check_val({tag, "_tv_stall"}, {31'b0, stall}, 32'd1);
    tick();
    check_val({tag, "_idle_stall"}, {31'b0, stall}, 32'd0);
    check_val({tag, "_idle_we"}, {31'b0, csr_we}, 32'd0);
  endtask

  task automatic pt_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    ex_csr_we    = 1'b1;
    ex_csr_waddr = addr;
    ex_csr_wdata = data;
    settle();
    expect_wr(tag, {20'b0, addr}, data);
    check_val({tag, "_stall"}, {31'b0, stall}, 32'd0);
    tick();
    ex_csr_we = 1'b0;
  endtask

  // Entered in cycle T with the trap inputs presented; returns in the E_ST cycle.
  task automatic entry(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                       input logic [31:0] tval, input logic [31:0] st, input logic [31:0] rpc);
    settle();
    check_val({tag, "_flush"}, {31'b0, flush}, 32'd1);
    check_val({tag, "_stall"}, {31'b0, stall}, 32'd1);
    tick();
    expect_wr({tag, "_mepc"}, 32'h341, epc);
    check_val({tag, "_rv_early"}, {31'b0, redirect_valid}, 32'd0);
    tick();
    expect_wr({tag, "_mcause"}, 32'h342, cause);
    tick();
    expect_wr({tag, "_mtval"}, 32'h343, tval);
    tick();
    expect_wr({tag, "_mstatus"}, 32'h300, st);
    check_val({tag, "_rv"}, {31'b0, redirect_valid}, 32'd1);
    check_val({tag, "_rpc"}, redirect_pc, rpc);
    check_val({tag, "_st_stall"}, {31'b0, stall}, 32'd1);
  endtask

  // Returns in the M_ST cycle.
  task automatic do_mret(input string tag, input logic [31:0] st, input logic [31:0] rpc);
    mret_valid = 1'b1;
    settle();
    check_val({tag, "_t_stall"}, {31'b0, stall}, 32'd1);
    check_val({tag, "_t_we"}, {31'b0, csr_we}, 32'd0);
    tick();
    mret_valid = 1'b0;
    expect_wr({tag, "_mstatus"}, 32'h300, st);
    check_val({tag, "_rv"}, {31'b0, redirect_valid}, 32'd1);
    check_val({tag, "_rpc"}, redirect_pc, rpc);
    check_val({tag, "_stall"}, {31'b0, stall}, 32'd1);
  endtask

  task automatic idle_check(input string tag);
    settle();
    check_val({tag, "_stall"}, {31'b0, stall}, 32'd0);
    check_val({tag, "_flush"}, {31'b0, flush}, 32'd0);
    check_val({tag, "_rv"}, {31'b0, redirect_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ex_csr_we = 1'b0; ex_csr_waddr = '0; ex_csr_wdata = '0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0;
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
    int_ok = 1'b0; int_pc = '0;

    repeat (3) tick();
    check_val("rst_stall", {31'b0, stall}, 32'd1);
    check_val("rst_we", {31'b0, csr_we}, 32'd0);
    check_val("rst_flush", {31'b0, flush}, 32'd0);
    check_val("rst_rv", {31'b0, redirect_valid}, 32'd0);
    check_val("rst_rpc", redirect_pc, 32'h0);
    check_val("rst_waddr", {20'b0, csr_waddr}, 32'h0);
    check_val("rst_wdata", csr_wdata, 32'h0);
    rst = 1'b0;
    init_seq("init");

    // Synchronous exception entry and return.
    pt_write("pt_mstatus", 12'h300, 32'h8);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
    entry("exc", 32'h40, 32'h2, 32'hDEAD, 32'h1880, 32'h100);
    exc_valid = 1'b0;
    tick();
    idle_check("exc_done");
    do_mret("mret1", 32'h1888, 32'h40);
    tick();
    idle_check("mret1_done");

    // Timer interrupt with mtvec in vectored mode.
    pt_write("pt_mie", 12'h304, 32'h80);
    pt_write("pt_mtvec", 12'h305, 32'h101);
    pt_write("pt_mstatus2", 12'h300, 32'h8);
    int_ok = 1'b1; int_pc = 32'h200; irq_timer = 1'b1;
    entry("tmr", 32'h200, 32'h8000_0007, 32'h0, 32'h1880, TGT_TIMER);
    irq_timer = 1'b0;
    tick();
    idle_check("tmr_done");
    do_mret("mret2", 32'h1888, 32'h200);
    tick();

    // Exception beats a simultaneous external interrupt; the interrupt follows the return.
    pt_write("pt_mie2", 12'h304, 32'h880);
    irq_ext = 1'b1; int_pc = 32'h300;
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h44; exc_tval = 32'h7;
    entry("exc_vs_ext", 32'h44, 32'h5, 32'h7, 32'h1880, 32'h100);
    exc_valid = 1'b0;
    tick();
    idle_check("ext_masked");
    do_mret("mret3", 32'h1888, 32'h44);
    tick();
    entry("ext", 32'h300, 32'h8000_000B, 32'h0, 32'h1880, TGT_EXT);
    irq_ext = 1'b0;
    tick();
    do_mret("mret4", 32'h1888, 32'h300);
    tick();

    // Interrupt deferred behind an EX CSR write, then reset lands in E_CAUSE.
    irq_timer = 1'b1; int_pc = 32'h400;
    ex_csr_we = 1'b1; ex_csr_waddr = 12'h343; ex_csr_wdata = 32'h5;
    settle();
    expect_wr("defer_pt", 32'h343, 32'h5);
    check_val("defer_flush", {31'b0, flush}, 32'd0);
    check_val("defer_stall", {31'b0, stall}, 32'd0);
    tick();
    ex_csr_we = 1'b0;
    settle();
    check_val("defer_take_flush", {31'b0, flush}, 32'd1);
    tick();
    expect_wr("defer_mepc", 32'h341, 32'h400);
    tick();
    expect_wr("defer_mcause", 32'h342, 32'h8000_0007);
    rst = 1'b1;
    irq_timer = 1'b0;
    settle();
    check_val("midrst_we", {31'b0, csr_we}, 32'd0);
    check_val("midrst_stall", {31'b0, stall}, 32'd1);
    check_val("midrst_rv", {31'b0, redirect_valid}, 32'd0);
    tick();
    rst = 1'b0;
    init_seq("reinit");

    // Shadows must show init values: no interrupt, mepc 0, mstatus 0, mtvec 0x100.
    irq_timer = 1'b1;
    idle_check("reinit_noirq");
    irq_timer = 1'b0;
    do_mret("mret5", 32'h1880, 32'h0);
    tick();
    exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h80; exc_tval = 32'h0;
    entry("exc2", 32'h80, 32'h3, 32'h0, 32'h1800, 32'h100);
    exc_valid = 1'b0;
    tick();
    idle_check("exc2_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
